mult_share_arbiter: RTL and testbench

//  Shares one combinational WallaceTree16bit multiplier among NREQ requesters.

---
 rtl/msa_pkg.sv | 14 +
 rtl/WallaceTree16bit.sv | 15 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/mult_share_arbiter.sv | 136 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/msa_pkg.sv
// msa_pkg: shared definitions for the multiplier-sharing arbiter.
//   MULT_W      operand width of the shared multiplier (fixed at 16)
//   IDLE/CALC/RESP  FSM state encoding used by mult_share_arbiter
package msa_pkg;

  localparam int MULT_W = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/WallaceTree16bit.sv
// WallaceTree16bit: combinational unsigned 16x16 multiplier shared by the
// arbiter. The product expression lets the synthesis tool build its own
// compressor tree / DSP mapping.
//   A     in   16  operand A
//   B     in   16  operand B
//   prod  out  32  unsigned A*B
module WallaceTree16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] prod
);

  assign prod = 32'(A) * 32'(B);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant selection.
//   req      in   NREQ  request vector
//   ptr      in   IDW   highest-priority index (owned by the parent)
//   en       in   1     grant enable; when low no grant is issued
//   gnt      out  NREQ  one-hot grant, or zero
//   gnt_idx  out  IDW   binary index of the grant (0 when no grant)
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  // Scan offsets from farthest to nearest so the request closest to ptr
  // (searching upward with wrap) overwrites any earlier candidate.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    if (en) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_idx  = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one WallaceTree16bit among NREQ requesters.
// Round-robin grant in IDLE, one CALC cycle with registered operands, then
// RESP holds the tagged product until the consumer takes it.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready one-hot or zero)
//   req_a/req_b              packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_prod          owning requester index and unsigned product
//   busy                     high whenever the FSM is not in IDLE
// Optional build macro MSA_PERF_CNT_EN adds cnt_clr (in) and grant_cnt
// (out, NREQ*16): one saturating accepted-request counter per requester.
// WIDTH must equal MULT_W because the multiplier is fixed at 16 bits.
module mult_share_arbiter
  import msa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_prod,
  output logic                  busy
`ifdef MSA_PERF_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [NREQ*16-1:0]    grant_cnt
`endif
);

  state_t             state_reg;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [IDW-1:0]     id_q;
  logic               rsp_valid_reg;
  logic [IDW-1:0]     rsp_id_reg;
  logic [2*WIDTH-1:0] rsp_prod_reg;

  logic               arb_en;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               accept;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [2*WIDTH-1:0] prod;

  // Gate with rst so no ready is ever advertised while reset is held.
  assign arb_en = (state_reg == IDLE) && !rst;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // gnt is only set where req_valid is set, so any grant is a transfer.
  assign req_ready = gnt;
  assign accept    = |gnt;
  assign a_sel     = req_a[gnt_idx*WIDTH +: WIDTH];
  assign b_sel     = req_b[gnt_idx*WIDTH +: WIDTH];

  WallaceTree16bit u_mult (
    .A    (a_q),
    .B    (b_q),
    .prod (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_prod_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_q        <= a_sel;
            b_q        <= b_sel;
            id_q       <= gnt_idx;
            rr_ptr_reg <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
            state_reg  <= CALC;
          end
        end
        CALC: begin
          rsp_prod_reg  <= prod;
          rsp_id_reg    <= id_q;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_prod  = rsp_prod_reg;
  assign busy      = (state_reg != IDLE);

`ifdef MSA_PERF_CNT_EN
  // Clear wins over increment; counters stick at 0xFFFF.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
          cnt_reg <= '0;
        end else if (gnt[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign grant_cnt[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed + random scoreboard bench for
// mult_share_arbiter. Define MSA_PERF_CNT_EN to also cover grant counters.
module tb_mult_share_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 2;
  localparam int IDW   = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;
  logic                  busy;
  logic                  cnt_clr;
  logic [NREQ*16-1:0]    grant_cnt;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
`ifdef MSA_PERF_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t        sb[$];
  int          grants[$];
  int          acc_cyc[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          pops     = 0;
  logic [31:0] last_prod;
  int          last_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes at the falling edge, then return #1 after
  // the rising edge where new inputs may be driven.
  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    if (busy) chk("ready_when_busy", 64'(req_ready), 64'd0);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = i;
        e.prod = 32'(req_a[i*WIDTH +: WIDTH]) * 32'(req_b[i*WIDTH +: WIDTH]);
        sb.push_back(e);
        grants.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_prod", 64'(rsp_prod), 64'(e.prod));
        last_prod = rsp_prod;
        last_id   = int'(rsp_id);
        pops++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input string tag);
    int g0 = grants.size();
    int n  = 0;
    while (grants.size() == g0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 64'(grants.size() > g0), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 60) begin
      step();
      n++;
    end
    chk(tag, 64'(sb.size() != 0 || busy), 64'd0);
  endtask

  task automatic op(input int id, input logic [15:0] a, input logic [15:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_valid = NREQ'(1) << id;
    rsp_ready = 1'b1;
    wait_grant("op_grant_timeout");
    req_valid = '0;
    drain("op_drain");
  endtask

  initial begin
    int n;
    int p0;
    rst       = 1'b1;
    req_valid = '1;
    req_a     = 32'h1234_5678;
    req_b     = 32'h9abc_def0;
    rsp_ready = 1'b0;
    cnt_clr   = 1'b0;
    last_prod = '0;
    last_id   = 0;

    // 1. Reset held with all requesters valid
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_prod", 64'(rsp_prod), 64'd0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;

    // 3. Fairness from rr_ptr=0 with both requesters always valid
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 16'(i + 2);
      req_b[i*WIDTH +: WIDTH] = 16'(i + 10);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    n = 0;
    while (grants.size() < 4 && n < 40) begin
      step();
      n++;
    end
    req_valid = '0;
    chk("fair_count", 64'(grants.size()), 64'd4);
    if (grants.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("fair_order", 64'(grants[k]), 64'(k % 2));
        if (k > 0) chk("fair_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
      end
    end
    drain("fair_drain");

    // 2. Single op with latency checks
    req_a = '0;
    req_b = '0;
    req_a[WIDTH-1:0] = 16'd3;
    req_b[WIDTH-1:0] = 16'd5;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    wait_grant("t2_grant_timeout");
    req_valid = '0;
    chk("t2_calc_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t2_calc_busy", 64'(busy), 64'd1);
    step();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_prod", 64'(rsp_prod), 64'd15);
    chk("t2_rsp_id", 64'(rsp_id), 64'd0);
    step();
    chk("t2_idle_busy", 64'(busy), 64'd0);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 4. Backpressure with the largest operands
    rsp_ready = 1'b0;
    req_a[WIDTH-1:0] = 16'hFFFF;
    req_b[WIDTH-1:0] = 16'hFFFF;
    req_a[2*WIDTH-1:WIDTH] = 16'd21;
    req_b[2*WIDTH-1:WIDTH] = 16'd2;
    req_valid = 2'b01;
    wait_grant("t4_grant_timeout");
    req_valid = 2'b11;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_prod", 64'(rsp_prod), 64'hFFFE0001);
      chk("bp_rsp_id", 64'(rsp_id), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_released_prod", 64'(last_prod), 64'hFFFE0001);
    step();
    chk("bp_next_grant", 64'(grants[$]), 64'd1);
    req_valid = '0;
    drain("bp_drain");

    // 5. Reset during CALC aborts the operation
    req_a[WIDTH-1:0] = 16'd11;
    req_b[WIDTH-1:0] = 16'd13;
    req_valid = 2'b01;
    wait_grant("t5_grant_timeout");
    req_valid = '0;
    chk("t5_in_calc", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("t5_abort_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    end
    op(1, 16'd7, 16'd9);
    chk("t5_prod", 64'(last_prod), 64'd63);
    chk("t5_id", 64'(last_id), 64'd1);

`ifdef MSA_PERF_CNT_EN
    // 6. Grant counters
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) op(1, 16'(k + 1), 16'd3);
    chk("cnt_slice1", 64'(grant_cnt[31:16]), 64'd4);
    chk("cnt_slice0", 64'(grant_cnt[15:0]), 64'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("cnt_clr_slice1", 64'(grant_cnt[31:16]), 64'd0);
    chk("cnt_clr_slice0", 64'(grant_cnt[15:0]), 64'd0);
`endif

    // Random ops against the A*B reference
    p0 = pops;
    n  = 0;
    while (pops < p0 + 10000 && n < 80000) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    req_valid = '0;
    chk("random_ops_done", 64'(pops - p0 >= 10000), 64'd1);
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
